// File: rtl/uart_bus_bridge_pkg.sv
// Shared command/reply byte codes, FSM state encoding and byte-lane helpers
// for the UART-to-bus bridge.
package uart_bus_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_BAD   = 8'h3F;
    localparam logic [7:0] RSP_TMO   = 8'h21;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_REPLY
    } state_t;

    function automatic logic [31:0] put_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[8*lane +: 8] = b;
        return w;
    endfunction

    function automatic logic [7:0] get_lane(input logic [31:0] word,
                                            input logic [1:0]  lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/uart_bus_bridge.sv
// Frame decoder turning UART command bytes into single-word bus loads/stores
// and streaming the reply bytes back through a ready/enable handshake.
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_en,
    input  logic        tx_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        bus_store,
    output logic        bus_load,
    input  logic        bus_ack
);

    localparam int unsigned   TW       = $clog2(BUS_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUS_TIMEOUT - 1);

    state_t        state, state_n;
    logic [1:0]    cnt, cnt_n;
    logic          is_write, is_write_n;
    logic [31:0]   addr_n, wdata_n;
    logic [31:0]   reply, reply_n;
    logic [1:0]    reply_last, reply_last_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [7:0]    tx_byte_n;
    logic          tx_en_n, load_n, store_n;
    logic          enter_reply;
    logic [31:0]   reply_word;
    logic [1:0]    reply_word_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            is_write   <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            reply      <= '0;
            reply_last <= '0;
            tmo        <= '0;
            tx_byte    <= '0;
            tx_en      <= 1'b0;
            bus_load   <= 1'b0;
            bus_store  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            is_write   <= is_write_n;
            bus_addr   <= addr_n;
            bus_wdata  <= wdata_n;
            reply      <= reply_n;
            reply_last <= reply_last_n;
            tmo        <= tmo_n;
            tx_byte    <= tx_byte_n;
            tx_en      <= tx_en_n;
            bus_load   <= load_n;
            bus_store  <= store_n;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        is_write_n      = is_write;
        addr_n          = bus_addr;
        wdata_n         = bus_wdata;
        reply_n         = reply;
        reply_last_n    = reply_last;
        tmo_n           = tmo;
        tx_byte_n       = tx_byte;
        tx_en_n         = tx_en;
        load_n          = bus_load;
        store_n         = bus_store;
        enter_reply     = 1'b0;
        reply_word      = '0;
        reply_word_last = '0;

        case (state)
            ST_IDLE: begin
                if (rx_byte_ready) begin
                    cnt_n = '0;
                    if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                        is_write_n = (rx_byte == CMD_WRITE);
                        state_n    = ST_ADDR;
                    end else begin
                        enter_reply = 1'b1;
                        reply_word  = {24'h0, RSP_BAD};
                    end
                end
            end
            ST_ADDR: begin
                if (rx_byte_ready) begin
                    addr_n = put_lane(bus_addr, cnt, rx_byte);
                    cnt_n  = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        if (is_write) begin
                            state_n = ST_DATA;
                        end else begin
                            state_n = ST_BUS;
                            load_n  = 1'b1;
                            tmo_n   = '0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_byte_ready) begin
                    wdata_n = put_lane(bus_wdata, cnt, rx_byte);
                    cnt_n   = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_n = ST_BUS;
                        store_n = 1'b1;
                        tmo_n   = '0;
                    end
                end
            end
            ST_BUS: begin
                // Ack is tested before the timeout so a same-cycle ack completes normally.
                if (bus_ack) begin
                    load_n      = 1'b0;
                    store_n     = 1'b0;
                    enter_reply = 1'b1;
                    if (is_write) begin
                        reply_word = {24'h0, RSP_OK};
                    end else begin
                        reply_word      = bus_rdata;
                        reply_word_last = 2'd3;
                    end
                end else if (tmo == TMO_LAST) begin
                    load_n      = 1'b0;
                    store_n     = 1'b0;
                    enter_reply = 1'b1;
                    reply_word  = {24'h0, RSP_TMO};
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            ST_REPLY: begin
                if (tx_en) begin
                    if (!tx_ready) begin
                        tx_en_n = 1'b0;
                        if (cnt == reply_last) begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 2'd1;
                        end
                    end
                end else if (tx_ready) begin
                    tx_en_n   = 1'b1;
                    tx_byte_n = get_lane(reply, cnt);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // First reply byte launches on the entry edge when the transmitter is idle.
        if (enter_reply) begin
            state_n      = ST_REPLY;
            reply_n      = reply_word;
            reply_last_n = reply_word_last;
            cnt_n        = '0;
            if (tx_ready) begin
                tx_en_n   = 1'b1;
                tx_byte_n = reply_word[7:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: frames in, bus responder and UART
// transmitter models, expected transactions and reply bytes derived from frames.
module tb_uart_bus_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_byte_ready = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_en;
    logic        tx_ready = 1'b1;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_store;
    logic        bus_load;
    logic        bus_ack = 1'b0;

    uart_bus_bridge #(.BUS_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_byte_ready(rx_byte_ready),
        .tx_byte      (tx_byte),
        .tx_en        (tx_en),
        .tx_ready     (tx_ready),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_store    (bus_store),
        .bus_load     (bus_load),
        .bus_ack      (bus_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model state
    int          exp_kind = 0;        // 0 none, 1 store, 2 load
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_rdata = '0;
    int          exp_ack_at = 0;      // request cycle carrying ack, 0 = never
    int          final_cyc = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    bit          tx_block = 1'b0;

    // Compare-process state
    int          busy = 0;
    int          req_cycles = 0;
    int          last_req_len = 0;
    bit          prev_req = 1'b0;
    bit          prev_en = 1'b0;
    bit          prev_rdy = 1'b1;
    bit          ack_reply = 1'b0;
    logic        req_now;
    logic [31:0] seen_addr = '0;
    logic [31:0] seen_wdata = '0;

    always @(negedge clk) begin
        bus_ack = 1'b0;
        if (rst) begin
            req_cycles = 0;
            prev_req   = 1'b0;
            ack_reply  = 1'b0;
        end else begin
            req_now = bus_load | bus_store;
            check("load_store_exclusive", {31'h0, bus_load & bus_store}, 32'h0);
            if (ack_reply) begin
                check("tx_latency_after_ack", {31'h0, tx_en}, 32'h1);
                ack_reply = 1'b0;
            end
            if (req_now) begin
                req_cycles++;
                if (!prev_req) begin
                    check("req_latency", cyc, final_cyc + 1);
                    check("req_kind", bus_store ? 1 : 2, exp_kind);
                    check("bus_addr", bus_addr, exp_addr);
                    if (bus_store) check("bus_wdata", bus_wdata, exp_wdata);
                    seen_addr  = bus_addr;
                    seen_wdata = bus_wdata;
                end else begin
                    check("bus_addr_stable", bus_addr, seen_addr);
                    check("bus_wdata_stable", bus_wdata, seen_wdata);
                end
                if (req_cycles == exp_ack_at) begin
                    bus_ack   = 1'b1;
                    bus_rdata = exp_rdata;
                end else begin
                    bus_rdata = $urandom;
                end
            end else if (prev_req) begin
                check("req_cycles", req_cycles,
                      (exp_ack_at != 0 && exp_ack_at <= TMO) ? exp_ack_at : TMO);
                last_req_len = req_cycles;
                req_cycles   = 0;
                exp_kind     = 0;
            end
            prev_req = req_now;
        end

        if (tx_en && !prev_en) check("tx_en_rise_needs_ready", {31'h0, prev_rdy}, 32'h1);
        if (tx_block) check("tx_withheld", {31'h0, tx_en}, 32'h0);

        // UART transmitter model
        if (tx_block) begin
            tx_ready = 1'b0;
        end else if (busy > 0) begin
            busy--;
        end else if (!tx_ready) begin
            tx_ready = 1'b1;
        end else if (tx_en) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected_byte", {24'h0, tx_byte}, 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", {24'h0, tx_byte}, {24'h0, exp_q.pop_front()});
            end
            got_q.push_back(tx_byte);
            tx_ready = 1'b0;
            busy     = 2;
        end

        ack_reply = bus_ack && tx_ready;
        prev_en   = tx_en;
        prev_rdy  = tx_ready;
    end

    function automatic logic [7:0] fb(input logic [71:0] f, input int len, input int i);
        return f[8*(len-1-i) +: 8];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte       = b;
        rx_byte_ready = 1'b1;
        final_cyc     = cyc;
        @(posedge clk); #1;
        rx_byte_ready = 1'b0;
        rx_byte       = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_kind != 0 || tx_en || !tx_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", {31'h0, n < budget}, 32'h1);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_values();
        check("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
        check("rst_tx_en", {31'h0, tx_en}, 32'h0);
        check("rst_bus_load", {31'h0, bus_load}, 32'h0);
        check("rst_bus_store", {31'h0, bus_store}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        exp_kind = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Frame bytes are written first-byte-leftmost; len is the byte count.
    task automatic frame(input logic [71:0] f, input int len, input int ack_at,
                         input logic [31:0] rdata, input bit wait_done);
        logic [7:0]  cmd;
        logic [31:0] a;
        logic [31:0] d;
        bit          tmo;
        cmd = fb(f, len, 0);
        a   = '0;
        d   = '0;
        tmo = (ack_at == 0) || (ack_at > TMO);
        got_q.delete();
        if (cmd == 8'h57 || cmd == 8'h52) begin
            for (int i = 0; i < 4; i++) a = a | (32'(fb(f, len, 1 + i)) << (8 * i));
            if (cmd == 8'h57)
                for (int i = 0; i < 4; i++) d = d | (32'(fb(f, len, 5 + i)) << (8 * i));
            exp_kind   = (cmd == 8'h57) ? 1 : 2;
            exp_addr   = a;
            exp_wdata  = d;
            exp_ack_at = ack_at;
            exp_rdata  = rdata;
            if (tmo) exp_q.push_back(8'h21);
            else if (cmd == 8'h57) exp_q.push_back(8'h4B);
            else for (int i = 0; i < 4; i++) exp_q.push_back(8'(rdata >> (8 * i)));
        end else begin
            exp_q.push_back(8'h3F);
        end
        for (int i = 0; i < len; i++) send_byte(fb(f, len, i));
        if (wait_done) wait_idle(400);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Write with ack in the 3rd request cycle
        frame({8'h57, 8'h00, 8'h20, 8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00}, 9, 3, 32'h0, 1'b1);
        check("w_addr_literal", seen_addr, 32'h0003_2000);
        check("w_wdata_literal", seen_wdata, 32'h0000_0001);
        check("w_reply_literal", {24'h0, got_q[0]}, 32'h4B);

        // Read with rdata returned byte-serially LSB first
        frame({8'h52, 8'h06, 8'h20, 8'h03, 8'h00}, 5, 2, 32'hA5B6_C7D8, 1'b1);
        check("r_addr_literal", seen_addr, 32'h0003_2006);
        check("r_reply_count", got_q.size(), 4);
        check("r_reply_literal", {got_q[3], got_q[2], got_q[1], got_q[0]}, 32'hA5B6_C7D8);

        // Unknown command, then a valid write acked in its first cycle
        frame({64'h0, 8'h13}, 1, 0, 32'h0, 1'b1);
        check("bad_reply_literal", {24'h0, got_q[0]}, 32'h3F);
        frame({8'h57, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 9, 1, 32'h0, 1'b1);
        check("w2_addr_literal", seen_addr, 32'h8000_0010);
        check("w2_wdata_literal", seen_wdata, 32'hDEAD_BEEF);

        // Timeout, ack on the final allowed cycle, ack one cycle too late
        frame({8'h52, 8'h04, 8'h00, 8'h00, 8'h00}, 5, 0, 32'h0, 1'b1);
        check("tmo_len_literal", last_req_len, 8);
        check("tmo_reply_literal", {24'h0, got_q[0]}, 32'h21);
        frame({8'h52, 8'h08, 8'h00, 8'h00, 8'h00}, 5, 8, 32'h1234_5678, 1'b1);
        check("ack_wins_len", last_req_len, 8);
        check("ack_wins_reply", {got_q[3], got_q[2], got_q[1], got_q[0]}, 32'h1234_5678);
        frame({8'h57, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00}, 9, 9, 32'h0, 1'b1);
        check("late_ack_reply", {24'h0, got_q[0]}, 32'h21);

        // Transmitter busy through REPLY with rx pulses injected in BUS and REPLY
        tx_block = 1'b1;
        repeat (2) @(posedge clk);
        frame({8'h52, 8'h40, 8'h00, 8'h00, 8'h00}, 5, 6, 32'h0BAD_F00D, 1'b0);
        send_byte(8'h57);
        send_byte(8'h52);
        repeat (6) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            send_byte((i % 2 == 0) ? 8'h57 : 8'h13);
            repeat (8) @(posedge clk);
        end
        check("blocked_nothing_sent", got_q.size(), 0);
        check("blocked_bus_done", exp_kind, 0);
        tx_block = 1'b0;
        wait_idle(200);
        check("blocked_reply_literal", {got_q[3], got_q[2], got_q[1], got_q[0]}, 32'h0BAD_F00D);
        frame({8'h57, 8'h44, 8'h00, 8'h00, 8'h00, 8'h77, 8'h66, 8'h00, 8'h00}, 9, 2, 32'h0, 1'b1);
        check("after_inject_reply", {24'h0, got_q[0]}, 32'h4B);

        // Reset after the third address byte, then a fresh frame
        got_q.delete();
        send_byte(8'h52);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        pulse_reset();
        repeat (10) @(posedge clk);
        check("abandoned_no_reply", got_q.size(), 0);
        frame({8'h52, 8'h10, 8'h32, 8'h54, 8'h76}, 5, 4, 32'hCAFE_0001, 1'b1);
        check("fresh_addr_literal", seen_addr, 32'h7654_3210);

        // Reset while a load request is held
        frame({8'h52, 8'h20, 8'h00, 8'h00, 8'h00}, 5, 0, 32'h0, 1'b0);
        n = 0;
        while (!bus_load && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("load_seen_before_reset", {31'h0, bus_load}, 32'h1);
        repeat (2) @(negedge clk);
        pulse_reset();
        got_q.delete();
        repeat (20) @(posedge clk);
        check("bus_abort_no_reply", got_q.size(), 0);
        frame({8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 9, 5, 32'h0, 1'b1);
        check("post_reset_wdata", seen_wdata, 32'h1234_5678);
        check("post_reset_reply", {24'h0, got_q[0]}, 32'h4B);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
